// File: rtl/data_memory_wait.sv
// data_memory_wait: byte-addressed MEM-stage data memory with fixed access latency.
// Byte/half/word loads and stores, sign/zero-extended loads, error response
// for misaligned or out-of-range accesses.
// Ports:
//   clk_i, rst_n_i      clock (rising), async active-low reset
//   req_i, we_i         request, 1 = store
//   size_i, unsigned_i  00 B, 01 H, 10 W (11 = error); zero-extend load
//   addr_i, wdata_i     byte address, store data
//   busy_o              stall while the access is pending
//   ack_o               one-cycle response pulse
//   rdata_o, err_o      load data and error flag, held until the next ack
module data_memory_wait #(
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              busy_o,
  output logic              ack_o,
  output logic [31:0]       rdata_o,
  output logic              err_o
);

  localparam int IDX_W = $clog2(DEPTH_BYTES);
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic             accept;
  logic             size_err;
  logic             range_err;
  logic             in_err;

  logic             cap_we_q;
  logic [1:0]       cap_size_q;
  logic             cap_uns_q;
  logic [IDX_W-1:0] cap_idx_q;
  logic [31:0]      cap_wdata_q;
  logic             cap_err_q;

  logic             a_we;
  logic [1:0]       a_size;
  logic             a_uns;
  logic [IDX_W-1:0] a_idx;
  logic [31:0]      a_wdata;
  logic             a_err;
  logic             do_access;

  logic [7:0]       mem [DEPTH_BYTES];
  logic [7:0]       b0, b1, b2, b3;
  logic [31:0]      load_val;

  logic [31:0]      rdata_q;
  logic             err_q;

  assign accept = req_i && (state_q != WAIT);

  always_comb begin
    size_err = 1'b0;
    unique case (size_i)
      2'b00:   size_err = 1'b0;
      2'b01:   size_err = addr_i[0];
      2'b10:   size_err = |addr_i[1:0];
      default: size_err = 1'b1;
    endcase
  end

  assign range_err = addr_i >= ADDR_W'(DEPTH_BYTES);
  assign in_err    = size_err || range_err;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cap_we_q    <= 1'b0;
      cap_size_q  <= 2'b00;
      cap_uns_q   <= 1'b0;
      cap_idx_q   <= '0;
      cap_wdata_q <= '0;
      cap_err_q   <= 1'b0;
    end else if (accept) begin
      cap_we_q    <= we_i;
      cap_size_q  <= size_i;
      cap_uns_q   <= unsigned_i;
      cap_idx_q   <= addr_i[IDX_W-1:0];
      cap_wdata_q <= wdata_i;
      cap_err_q   <= in_err;
    end
  end

  // Single-cycle accesses complete on the accept edge from the live
  // inputs; longer ones complete from the captured copy.
  assign a_we    = (LATENCY == 1) ? we_i : cap_we_q;
  assign a_size  = (LATENCY == 1) ? size_i : cap_size_q;
  assign a_uns   = (LATENCY == 1) ? unsigned_i : cap_uns_q;
  assign a_idx   = (LATENCY == 1) ? addr_i[IDX_W-1:0] : cap_idx_q;
  assign a_wdata = (LATENCY == 1) ? wdata_i : cap_wdata_q;
  assign a_err   = (LATENCY == 1) ? in_err : cap_err_q;

  assign do_access = (LATENCY == 1) ? accept
                   : (state_q == WAIT) && (cnt_q == '0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, RESP: begin
        if (req_i) begin
          state_d = (LATENCY == 1) ? RESP : WAIT;
          cnt_d   = CNT_INIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Index arithmetic wraps within IDX_W; wrapped bytes are only
  // reachable by accesses already flagged as errors.
  assign b0 = mem[a_idx];
  assign b1 = mem[a_idx + IDX_W'(1)];
  assign b2 = mem[a_idx + IDX_W'(2)];
  assign b3 = mem[a_idx + IDX_W'(3)];

  always_comb begin
    load_val = '0;
    unique case (a_size)
      2'b00:
        load_val = a_uns ? {24'b0, b0}
                         : {{24{b0[7]}}, b0};
      2'b01:
        load_val = a_uns ? {16'b0, b1, b0}
                         : {{16{b1[7]}}, b1, b0};
      default:
        load_val = {b3, b2, b1, b0};
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (do_access && !a_err && a_we) begin
      unique case (a_size)
        2'b00: begin
          mem[a_idx] <= a_wdata[7:0];
        end
        2'b01: begin
          mem[a_idx]              <= a_wdata[7:0];
          mem[a_idx + IDX_W'(1)]  <= a_wdata[15:8];
        end
        2'b10: begin
          mem[a_idx]              <= a_wdata[7:0];
          mem[a_idx + IDX_W'(1)]  <= a_wdata[15:8];
          mem[a_idx + IDX_W'(2)]  <= a_wdata[23:16];
          mem[a_idx + IDX_W'(3)]  <= a_wdata[31:24];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (do_access) begin
      if (a_err) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end else if (a_we) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end else begin
        rdata_q <= load_val;
        err_q   <= 1'b0;
      end
    end
  end

  assign busy_o  = (state_q == WAIT);
  assign ack_o   = (state_q == RESP);
  assign rdata_o = rdata_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_data_memory_wait.sv
// tb_data_memory_wait: bench for data_memory_wait at LATENCY 1, 3, 2 and 4.
// Expected responses are queued at drive time and popped on ack.
module tb_data_memory_wait;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req;
  logic        d_we;
  logic [1:0]  d_size;
  logic        d_uns;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  busy;
  logic [3:0]  ack;
  logic [3:0]  err;
  logic [31:0] rdata [4];

  int n_chk = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [31:0] rd;
    logic        er;
  } exp_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        er;
  } op_t;

  exp_t sb[$];

  localparam logic [1:0] SB_ = 2'b00;
  localparam logic [1:0] SH_ = 2'b01;
  localparam logic [1:0] SW_ = 2'b10;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 2 : 4;
    data_memory_wait #(
      .DEPTH_BYTES(1024),
      .LATENCY(L),
      .ADDR_W(32)
    ) u_dut (
      .clk_i(clk),
      .rst_n_i(rst_n),
      .req_i(req[g]),
      .we_i(d_we),
      .size_i(d_size),
      .unsigned_i(d_uns),
      .addr_i(d_addr),
      .wdata_i(d_wdata),
      .busy_o(busy[g]),
      .ack_o(ack[g]),
      .rdata_o(rdata[g]),
      .err_o(err[g])
    );
  end

  function automatic int lat_of(int k);
    case (k)
      0: return 1;
      1: return 3;
      2: return 2;
      default: return 4;
    endcase
  endfunction

  function automatic op_t mk(logic we, logic [1:0] sz, logic uns,
                             logic [31:0] a, logic [31:0] wd,
                             logic [31:0] rd, logic er);
    op_t o;
    o.we = we; o.sz = sz; o.uns = uns; o.addr = a;
    o.wd = wd; o.rd = rd; o.er = er;
    return o;
  endfunction

  // Drive one request, scramble inputs after accept, observe the ack.
  task automatic run_op(input int k, input op_t o,
                        output logic [31:0] rd, output logic er,
                        output int lat, output int nb,
                        output logic xa);
    @(negedge clk);
    d_we = o.we; d_size = o.sz; d_uns = o.uns;
    d_addr = o.addr; d_wdata = o.wd; req[k] = 1'b1;
    @(posedge clk);
    #1;
    req[k] = 1'b0;
    d_addr = $urandom; d_wdata = $urandom;
    d_we = ~d_we; d_size = 2'($urandom); d_uns = ~d_uns;
    lat = 0; nb = 0; rd = '0; er = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ack[k]) begin
        lat = n; rd = rdata[k]; er = err[k];
        break;
      end
      nb += int'(busy[k]);
    end
    @(negedge clk);
    xa = ack[k];
  endtask

  task automatic exec_ops(input string nm, input int k, input op_t ops[$]);
    logic [31:0] rd;
    logic er, xa;
    int lat, nb, L;
    exp_t e;
    L = lat_of(k);
    foreach (ops[i]) begin
      sb.push_back({ops[i].rd, ops[i].er});
      run_op(k, ops[i], rd, er, lat, nb, xa);
      e = sb.pop_front();
      n_chk++;
      if (rd !== e.rd)
        $display("FAIL %s[%0d] rdata got %h want %h", nm, i, rd, e.rd);
      else n_pass++;
      n_chk++;
      if (er !== e.er)
        $display("FAIL %s[%0d] err got %b want %b", nm, i, er, e.er);
      else n_pass++;
      n_chk++;
      if (lat != L || nb != L - 1 || xa !== 1'b0)
        $display("FAIL %s[%0d] timing lat=%0d busy=%0d xack=%b want %0d/%0d/0",
                 nm, i, lat, nb, xa, L, L - 1);
      else n_pass++;
    end
  endtask

  task automatic test_reset;
    #2;
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if ({busy[k], ack[k], err[k], rdata[k]} !== 35'd0)
        $display("FAIL reset[%0d] busy=%b ack=%b err=%b rdata=%h want all 0",
                 k, busy[k], ack[k], err[k], rdata[k]);
      else n_pass++;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_word_l1;
    op_t ops[$];
    ops = '{mk(1, SW_, 0, 32'h10, 32'h8000_00FF, 32'h0, 0),
            mk(0, SW_, 0, 32'h10, 32'h0, 32'h8000_00FF, 0)};
    exec_ops("word_l1", 0, ops);
  endtask

  task automatic test_byte_l3;
    op_t ops[$];
    ops = '{mk(1, SB_, 0, 32'h21, 32'h1234_56AB, 32'h0, 0),
            mk(0, SB_, 0, 32'h21, 32'h0, 32'hFFFF_FFAB, 0),
            mk(0, SB_, 1, 32'h21, 32'h0, 32'h0000_00AB, 0)};
    exec_ops("byte_l3", 1, ops);
  endtask

  task automatic test_half;
    op_t ops[$];
    ops = '{mk(1, SW_, 0, 32'h40, 32'h0, 32'h0, 0),
            mk(1, SH_, 0, 32'h40, 32'hFFFF_1234, 32'h0, 0),
            mk(0, SH_, 0, 32'h40, 32'h0, 32'h0000_1234, 0),
            mk(0, SW_, 0, 32'h40, 32'h0, 32'h0000_1234, 0),
            mk(0, SB_, 1, 32'h41, 32'h0, 32'h0000_0012, 0),
            mk(1, SH_, 0, 32'h44, 32'h0000_8001, 32'h0, 0),
            mk(0, SH_, 0, 32'h44, 32'h0, 32'hFFFF_8001, 0),
            mk(0, SH_, 1, 32'h44, 32'h0, 32'h0000_8001, 0)};
    exec_ops("half", 1, ops);
  endtask

  task automatic test_errors;
    op_t ops[$];
    ops = '{mk(1, SW_, 0, 32'h0, 32'h5A5A_1234, 32'h0, 0),
            mk(0, SW_, 0, 32'h2, 32'h0, 32'h0, 1),
            mk(0, SH_, 0, 32'h3, 32'h0, 32'h0, 1),
            mk(1, 2'b11, 0, 32'h0, 32'hFFFF_FFFF, 32'h0, 1),
            mk(1, SW_, 0, 32'd1024, 32'hFFFF_FFFF, 32'h0, 1),
            mk(1, SW_, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h0, 1),
            mk(1, SW_, 0, 32'h3FC, 32'h0BAD_F00D, 32'h0, 0),
            mk(0, SW_, 0, 32'h3FC, 32'h0, 32'h0BAD_F00D, 0),
            mk(0, SW_, 0, 32'h0, 32'h0, 32'h5A5A_1234, 0)};
    exec_ops("errors", 0, ops);
    repeat (3) @(negedge clk);
    n_chk++;
    if (rdata[0] !== 32'h5A5A_1234 || err[0] !== 1'b0)
      $display("FAIL hold rdata=%h err=%b want 5a5a1234/0", rdata[0], err[0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    op_t ops[$];
    logic seen;
    ops = '{mk(1, SW_, 0, 32'h8, 32'h1122_3344, 32'h0, 0)};
    exec_ops("rst_pre", 3, ops);
    @(negedge clk);
    d_we = 1'b1; d_size = SW_; d_uns = 1'b0;
    d_addr = 32'h8; d_wdata = 32'hDEAD_BEEF; req[3] = 1'b1;
    @(posedge clk);
    #1;
    req[3] = 1'b0;
    @(posedge clk);
    #1;
    n_chk++;
    if (busy[3] !== 1'b1)
      $display("FAIL rst_mid wait busy=%b want 1", busy[3]);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (busy[3] !== 1'b0 || ack[3] !== 1'b0)
      $display("FAIL rst_mid async busy=%b ack=%b want 0/0", busy[3], ack[3]);
    else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | ack[3] | busy[3];
    end
    n_chk++;
    if (seen !== 1'b0)
      $display("FAIL rst_mid ack/busy after release got %b want 0", seen);
    else n_pass++;
    ops = '{mk(0, SW_, 0, 32'h8, 32'h0, 32'h1122_3344, 0)};
    exec_ops("rst_post", 3, ops);
  endtask

  task automatic test_back_to_back;
    int nack;
    int t [2];
    exp_t e;
    nack = 0;
    t[0] = 0; t[1] = 0;
    @(negedge clk);
    d_we = 1'b1; d_size = SW_; d_uns = 1'b0;
    d_addr = 32'h0; d_wdata = 32'hCAFE_F00D; req[2] = 1'b1;
    sb.push_back({32'h0, 1'b0});
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (ack[2]) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL b2b unexpected ack at cycle %0d want none", cyc);
        end else begin
          e = sb.pop_front();
          n_chk++;
          if (rdata[2] !== e.rd || err[2] !== e.er)
            $display("FAIL b2b ack%0d rdata=%h err=%b want %h/%b",
                     nack, rdata[2], err[2], e.rd, e.er);
          else n_pass++;
        end
        if (nack < 2) t[nack] = cyc;
        nack++;
      end
      if (cyc == 2) begin
        d_we = 1'b0; d_addr = 32'h0; d_wdata = $urandom;
        sb.push_back({32'hCAFE_F00D, 1'b0});
      end
      if (cyc == 3) req[2] = 1'b0;
    end
    n_chk++;
    if (nack != 2 || t[0] != 2 || t[1] - t[0] != 2 || sb.size() != 0)
      $display("FAIL b2b acks=%0d at %0d,%0d left=%0d want 2 at 2,4 left=0",
               nack, t[0], t[1], sb.size());
    else n_pass++;
    sb.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    req = '0;
    d_we = 1'b0; d_size = 2'b00; d_uns = 1'b0;
    d_addr = '0; d_wdata = '0;
    test_reset();
    test_word_l1();
    test_byte_l3();
    test_half();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
